input_conditioner: RTL and testbench
====================================

# input_conditioner

Multi-channel input conditioner for asynchronous external signals (buttons, switches, handshake lines) entering the ALU clock domain. Each channel gets a configurable-depth synchronizer chain, an optional debounce filter, one-cycle rise/fall edge pulses, and sticky edge flags that software or control logic clears explicitly. It replaces ad-hoc per-signal two-flop synchronizers at the top level.

## Interface

Parameters:
- CHANNELS, 4: number of independent input channels (≥1).
- SYNC_STAGES, 2: synchronizer flops per channel (≥2).
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before `level` follows the input (≥1). Only used when debounce is compiled in.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- signal  input  CHANNELS  raw asynchronous inputs.
- flag_clr  input  CHANNELS  synchronous clear of `rise_flag[i]`/`fall_flag[i]`.
- level  output  CHANNELS  conditioned, registered level.
- rise_edge  output  CHANNELS  one-cycle pulse: `level[i]` went 0→1 this cycle.
- fall_edge  output  CHANNELS  one-cycle pulse: `level[i]` went 1→0 this cycle.
- rise_flag  output  CHANNELS  sticky, set by `rise_edge[i]`.
- fall_flag  output  CHANNELS  sticky, set by `fall_edge[i]`.

## Operation

- Reset (`rst` low, asynchronous): all synchronizer stages, counters, `level`, `rise_edge`, `fall_edge`, `rise_flag` and `fall_flag` go to 0.
- Channels are fully independent. No cross-channel interaction.
- Sync chain: `signal[i]` passes through SYNC_STAGES flops. The last stage is `s[i]`.
- Debounce, per channel:
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`. Counter is 0 at reset.
  - If `s[i] == level[i]`: counter is cleared to 0.
  - If `s[i] != level[i]` and counter < DEBOUNCE_CYCLES-1: counter increments.
  - If `s[i] != level[i]` and counter == DEBOUNCE_CYCLES-1: `level[i] <= s[i]`, counter is cleared, and the matching edge pulse is registered.
  - Counter never wraps.
  - A disagreement lasting fewer than DEBOUNCE_CYCLES cycles is discarded with no level change and no edge.
- Edges are registered and asserted in the same cycle `level[i]` takes its new value. Otherwise they are 0. Rise and fall never assert together on a channel.
- Flags:
  - The edge pulse sets the flag.
  - `flag_clr[i]` clears both flags of channel i.
  - If set and clear occur in the same cycle, set wins.
- Reset release with `signal[i]` high: `level[i]` starts at 0, so one `rise_edge[i]` follows after the normal latency. This is intended.

## Timing

- Latency with debounce: a change is first captured at edge k. `level`/edge update at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
- Latency without debounce: `level` update at edge k+SYNC_STAGES.
- Edge pulses are exactly 1 cycle wide.
- Flags update 1 cycle after the edge pulse. The cycle after a clear, the flag reads 0.
- All outputs are registered. No combinational path from any input to any output.

## Configuration

- `INPUT_COND_DEBOUNCE_EN` defined: debounce counters are present, and behaviour is as in Operation.
- `INPUT_COND_DEBOUNCE_EN` undefined:
  - No counters are built and DEBOUNCE_CYCLES is ignored.
  - `level[i] <= s[i]` every cycle.
  - Edges fire on every `s[i]` transition, including 1-cycle glitches.
  - Flags behave the same.

## Structure

- Package `input_cond_pkg`: default constants DEF_CHANNELS, DEF_SYNC_STAGES, DEF_DEBOUNCE_CYCLES, and a `cnt_width(int)` function returning `$clog2(n+1)`.
- Sub-module `input_cond_channel`: one channel (sync chain, debounce, edges, flags). The top instantiates it with a generate loop over CHANNELS.

## Test plan

Configuration: CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, macro defined unless noted.

- Reset: hold `rst`=0 with `signal`=4'hF and toggle the clock → all outputs stay 0. Release reset → `level`=4'hF, `rise_edge`=4'hF for exactly 1 cycle, 5 edges after release.
- Clean rise: ch0 driven 0→1 and held → `level[0]`=1 and `rise_edge[0]` pulses at edge k+5. `rise_flag[0]`=1 from the next cycle. Other channels are unchanged.
- Glitch reject: ch1 high for 3 cycles, then low → `level[1]`, `rise_edge[1]` and `rise_flag[1]` remain 0 throughout.
- Flag clear race: assert `flag_clr[2]` in the same cycle `rise_edge[2]` pulses → `rise_flag[2]`=1. Assert `flag_clr[2]` alone later → 0 the next cycle.
- Mid-count reset: ch3 high, pull `rst` low after 2 debounce cycles → counter and `level[3]` go to 0 immediately. After release, the full 5-edge latency is required again.
- Macro undefined: ch0 single-cycle high pulse → `level[0]` high for 1 cycle at edge k+2. `rise_edge[0]` and `fall_edge[0]` pulse on consecutive cycles.

Source files
------------

// File: rtl/input_cond_pkg.sv
// Shared defaults and helpers for the input conditioner.
package input_cond_pkg;

    localparam int unsigned DEF_CHANNELS        = 4;
    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;

    // Bits needed to hold a count of 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/input_cond_channel.sv
// One conditioned input channel: synchronizer chain, optional debounce,
// registered edge pulses and sticky edge flags.
// Debounce is compiled in only when INPUT_COND_DEBOUNCE_EN is defined.
module input_cond_channel
    import input_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)(
    input  logic clock,
    input  logic rst,
    input  logic signal,
    input  logic flag_clr,
    output logic level,
    output logic rise_edge,
    output logic fall_edge,
    output logic rise_flag,
    output logic fall_flag
);

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("input_cond_channel: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb
        $error("input_cond_channel: DEBOUNCE_CYCLES must be at least 1");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level;
    logic                   r_rise_edge;
    logic                   r_fall_edge;
    logic                   r_rise_flag;
    logic                   r_fall_flag;
    logic                   w_s;
    logic                   w_change;

    assign w_s = r_sync[SYNC_STAGES-1];

    // Metastability chain; bit 0 samples the raw pin.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], signal};
        end
    end

`ifdef INPUT_COND_DEBOUNCE_EN
    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    // Count consecutive disagreement cycles; accept the new value on the last one.
    always_comb begin
        w_change   = 1'b0;
        w_cnt_next = '0;
        if (w_s != r_level) begin
            if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                w_change = 1'b1;
            end else begin
                w_cnt_next = r_cnt + CW'(1);
            end
        end
    end

    // Debounce counter register.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end
`else
    // Without debounce the level tracks the synchronized input every cycle.
    assign w_change = (w_s != r_level);
`endif

    // Level update with edge pulses registered alongside it.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_level     <= 1'b0;
            r_rise_edge <= 1'b0;
            r_fall_edge <= 1'b0;
        end else begin
            if (w_change) begin
                r_level <= w_s;
            end
            r_rise_edge <= w_change &  w_s;
            r_fall_edge <= w_change & ~w_s;
        end
    end

    // Sticky flags: a pulse in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_rise_flag <= 1'b0;
            r_fall_flag <= 1'b0;
        end else begin
            r_rise_flag <= r_rise_edge | (r_rise_flag & ~flag_clr);
            r_fall_flag <= r_fall_edge | (r_fall_flag & ~flag_clr);
        end
    end

    assign level     = r_level;
    assign rise_edge = r_rise_edge;
    assign fall_edge = r_fall_edge;
    assign rise_flag = r_rise_flag;
    assign fall_flag = r_fall_flag;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel conditioner for asynchronous inputs entering the clock domain.
// Optional debounce filter enabled by defining INPUT_COND_DEBOUNCE_EN.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int unsigned CHANNELS        = DEF_CHANNELS,
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)(
    input  logic                clock,
    input  logic                rst,
    input  logic [CHANNELS-1:0] signal,
    input  logic [CHANNELS-1:0] flag_clr,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise_edge,
    output logic [CHANNELS-1:0] fall_edge,
    output logic [CHANNELS-1:0] rise_flag,
    output logic [CHANNELS-1:0] fall_flag
);

    if (CHANNELS < 1) begin : g_chk_ch
        $error("input_conditioner: CHANNELS must be at least 1");
    end

    // One independent channel per input bit.
    for (genvar gi = 0; gi < int'(CHANNELS); gi++) begin : g_ch
        input_cond_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clock     (clock),
            .rst       (rst),
            .signal    (signal[gi]),
            .flag_clr  (flag_clr[gi]),
            .level     (level[gi]),
            .rise_edge (rise_edge[gi]),
            .fall_edge (fall_edge[gi]),
            .rise_flag (rise_flag[gi]),
            .fall_flag (fall_flag[gi])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner (CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Follows whichever INPUT_COND_DEBOUNCE_EN setting the design is built with.
`timescale 1ns/1ps
module tb_input_conditioner;

    localparam int unsigned CH = 4;
    localparam int unsigned SS = 2;
    localparam int unsigned DB = 4;
`ifdef INPUT_COND_DEBOUNCE_EN
    localparam int LAT = SS + DB - 1;
`else
    localparam int LAT = SS;
`endif

    logic          clock    = 1'b0;
    logic          rst      = 1'b0;
    logic [CH-1:0] signal   = '0;
    logic [CH-1:0] flag_clr = '0;
    logic [CH-1:0] level;
    logic [CH-1:0] rise_edge;
    logic [CH-1:0] fall_edge;
    logic [CH-1:0] rise_flag;
    logic [CH-1:0] fall_flag;

    int n_cmp = 0;
    int n_err = 0;

    input_conditioner #(
        .CHANNELS        (CH),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .signal    (signal),
        .flag_clr  (flag_clr),
        .level     (level),
        .rise_edge (rise_edge),
        .fall_edge (fall_edge),
        .rise_flag (rise_flag),
        .fall_flag (fall_flag)
    );

    always #5 clock = ~clock;

    // Advance n rising edges, then settle 1ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [CH-1:0] lv, input logic [CH-1:0] re,
                             input logic [CH-1:0] fe, input logic [CH-1:0] rf, input logic [CH-1:0] ff);
        check({tag, ".level"},     level,     lv);
        check({tag, ".rise_edge"}, rise_edge, re);
        check({tag, ".fall_edge"}, fall_edge, fe);
        check({tag, ".rise_flag"}, rise_flag, rf);
        check({tag, ".fall_flag"}, fall_flag, ff);
    endtask

    initial begin
        // Reset held with all inputs high: nothing moves.
        rst    = 1'b0;
        signal = 4'hF;
        tick(3);
        check_all("reset_hold", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

        // Release: first edge captures, level follows LAT edges later.
        rst = 1'b1;
        tick(LAT);
        check_all("release_pre", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        tick(1);
        check_all("release_rise", 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
        tick(1);
        check_all("release_post", 4'hF, 4'h0, 4'h0, 4'hF, 4'h0);

        // All channels fall, then clear every flag.
        signal = 4'h0;
        tick(LAT + 1);
        check_all("fall_all", 4'h0, 4'h0, 4'hF, 4'hF, 4'h0);
        tick(1);
        check_all("fall_post", 4'h0, 4'h0, 4'h0, 4'hF, 4'hF);
        flag_clr = 4'hF;
        tick(1);
        check_all("clr_all", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        flag_clr = 4'h0;

        // Clean rise on ch0.
        signal = 4'h1;
        tick(LAT);
        check_all("ch0_pre", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        tick(1);
        check_all("ch0_rise", 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
        tick(1);
        check_all("ch0_flag", 4'h1, 4'h0, 4'h0, 4'h1, 4'h0);

`ifdef INPUT_COND_DEBOUNCE_EN
        // ch1 high for 3 cycles is shorter than the debounce window.
        signal = 4'h3;
        tick(3);
        signal = 4'h1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check_all($sformatf("glitch_c%0d", i), 4'h1, 4'h0, 4'h0, 4'h1, 4'h0);
        end
`else
        // ch1 one-cycle pulse passes straight through.
        signal = 4'h3;
        tick(1);
        signal = 4'h1;
        tick(1);
        check_all("pulse_k1", 4'h1, 4'h0, 4'h0, 4'h1, 4'h0);
        tick(1);
        check_all("pulse_k2", 4'h3, 4'h2, 4'h0, 4'h1, 4'h0);
        tick(1);
        check_all("pulse_k3", 4'h1, 4'h0, 4'h2, 4'h3, 4'h0);
        tick(1);
        check_all("pulse_k4", 4'h1, 4'h0, 4'h0, 4'h3, 4'h2);
        flag_clr = 4'h2;
        tick(1);
        check_all("pulse_clr", 4'h1, 4'h0, 4'h0, 4'h1, 4'h0);
        flag_clr = 4'h0;
`endif

        // ch2 rise with a clear in the pulse cycle: the set wins.
        signal = 4'h5;
        tick(LAT + 1);
        check_all("race_edge", 4'h5, 4'h4, 4'h0, 4'h1, 4'h0);
        flag_clr = 4'h4;
        tick(1);
        check_all("race_set_wins", 4'h5, 4'h0, 4'h0, 4'h5, 4'h0);
        flag_clr = 4'h0;
        tick(1);
        check("race_hold.rise_flag", rise_flag, 4'h5);
        flag_clr = 4'h4;
        tick(1);
        check("race_clear.rise_flag", rise_flag, 4'h1);
        check("race_clear.level", level, 4'h5);
        flag_clr = 4'h0;

        // ch3 rises, reset arrives mid-way through the filter.
        signal = 4'hD;
`ifdef INPUT_COND_DEBOUNCE_EN
        tick(4);
`else
        tick(1);
`endif
        check_all("midrst_pre", 4'h5, 4'h0, 4'h0, 4'h1, 4'h0);
        #2 rst = 1'b0;
        #1;
        check_all("midrst_async", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        tick(2);
        check_all("midrst_held", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        rst = 1'b1;
        tick(LAT);
        check_all("midrst_relat", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        tick(1);
        check_all("midrst_rise", 4'hD, 4'hD, 4'h0, 4'h0, 4'h0);
        tick(1);
        check_all("midrst_flag", 4'hD, 4'h0, 4'h0, 4'hD, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
